memory_requester: RTL

MEMORY_REQUESTER -- requirements
Module: memory_requester

---
 rtl/memory_requester_if.sv | 38 +++
 rtl/memory_requester.sv | 120 ++++++++++++
 2 files changed

// File: rtl/memory_requester_if.sv
// Client request/response and memory-side signals of the memory requester.
// The slave modport is the requester's view; master is the client plus memory.
interface memory_requester_if #(
   parameter int ADDRESS_SIZE    = 12,
   parameter int CACHE_LINE_SIZE = 128
);
   logic                       req_valid;
   logic                       req_op;
   logic [ADDRESS_SIZE-1:0]    req_address;
   logic [CACHE_LINE_SIZE-1:0] req_data;
   logic                       req_ready;
   logic                       resp_valid;
   logic [CACHE_LINE_SIZE-1:0] resp_data;
   logic                       resp_error;
   logic                       mem_enable;
   logic                       mem_op;
   logic                       mem_op_init;
   logic                       mem_op_done;
   logic [ADDRESS_SIZE-1:0]    mem_address;
   logic [CACHE_LINE_SIZE-1:0] mem_data_out;
   logic [CACHE_LINE_SIZE-1:0] mem_data_in;
   logic                       mem_data_ready;
   logic                       mem_in_use;

   modport slave (
      input  req_valid, req_op, req_address, req_data,
      input  mem_data_in, mem_data_ready, mem_in_use,
      output req_ready, resp_valid, resp_data, resp_error,
      output mem_enable, mem_op, mem_op_init, mem_op_done, mem_address, mem_data_out
   );

   modport master (
      output req_valid, req_op, req_address, req_data,
      output mem_data_in, mem_data_ready, mem_in_use,
      input  req_ready, resp_valid, resp_data, resp_error,
      input  mem_enable, mem_op, mem_op_init, mem_op_done, mem_address, mem_data_out
   );
endinterface

// File: rtl/memory_requester.sv
// Turns one client line read/write into a single arbitrated memory operation,
// with a bounded wait and a one-cycle completion pulse.
module memory_requester #(
   parameter int ADDRESS_SIZE    = 12,
   parameter int CACHE_LINE_SIZE = 128,
   parameter int TIMEOUT_CYCLES  = 16
) (
   input  logic                clk,
   input  logic                reset,
   memory_requester_if.slave   bus
);
   localparam int OFFSET_BITS = $clog2(CACHE_LINE_SIZE / 8);
   localparam int CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK  = {ADDRESS_SIZE{1'b1}} << OFFSET_BITS;
   localparam logic [CNT_W-1:0]        TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, ARB, WAIT, DONE} state_t;

   state_t                     state_q;
   logic [CNT_W-1:0]           cnt_q;
   logic [CNT_W-1:0]           cnt_d;
   logic                       err_q;
   logic                       op_q;
   logic [ADDRESS_SIZE-1:0]    addr_q;
   logic [CACHE_LINE_SIZE-1:0] wdata_q;
   logic                       mem_enable_q;
   logic                       mem_op_init_q;
   logic                       mem_op_done_q;
   logic                       req_ready_q;
   logic                       resp_valid_q;
   logic                       resp_error_q;
   logic [CACHE_LINE_SIZE-1:0] resp_data_q;

   assign cnt_d = cnt_q + CNT_W'(1);

   // Memory controls are registered so mem_enable falls the cycle after data is seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         err_q         <= 1'b0;
         op_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         mem_enable_q  <= 1'b0;
         mem_op_init_q <= 1'b0;
         mem_op_done_q <= 1'b0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_error_q  <= 1'b0;
         resp_data_q   <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  op_q        <= bus.req_op;
                  addr_q      <= bus.req_address & ALIGN_MASK;
                  wdata_q     <= bus.req_data;
                  err_q       <= 1'b0;
                  req_ready_q <= 1'b0;
                  state_q     <= ARB;
               end
            end
            ARB: begin
               if (!bus.mem_in_use) begin
                  cnt_q         <= '0;
                  mem_enable_q  <= 1'b1;
                  mem_op_init_q <= 1'b1;
                  state_q       <= WAIT;
               end
            end
            WAIT: begin
               // Data arriving on the timeout cycle still counts as success.
               if (bus.mem_data_ready) begin
                  if (!op_q) begin
                     resp_data_q <= bus.mem_data_in;
                  end
                  err_q         <= 1'b0;
                  mem_enable_q  <= 1'b0;
                  mem_op_init_q <= 1'b0;
                  mem_op_done_q <= 1'b1;
                  state_q       <= DONE;
               end else begin
                  cnt_q <= cnt_d;
                  if (cnt_d == TIMEOUT_CNT) begin
                     err_q         <= 1'b1;
                     mem_enable_q  <= 1'b0;
                     mem_op_init_q <= 1'b0;
                     mem_op_done_q <= 1'b1;
                     state_q       <= DONE;
                  end
               end
            end
            DONE: begin
               if (!bus.mem_data_ready) begin
                  mem_op_done_q <= 1'b0;
                  resp_valid_q  <= 1'b1;
                  resp_error_q  <= err_q;
                  req_ready_q   <= 1'b1;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready    = req_ready_q;
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_data    = resp_data_q;
   assign bus.resp_error   = resp_error_q;
   assign bus.mem_enable   = mem_enable_q;
   assign bus.mem_op       = op_q;
   assign bus.mem_op_init  = mem_op_init_q;
   assign bus.mem_op_done  = mem_op_done_q;
   assign bus.mem_address  = addr_q;
   assign bus.mem_data_out = wdata_q;
endmodule
